// File: rtl/apb_mem_slave_param.sv
// apb_mem_slave_param
//
// APB3 memory slave. Its data width, depth, base address and number of wait
// states are set by parameters. Each word is reset to zero. A transfer returns
// PSLVERR when the address is out of range, when the address is misaligned, or
// when the master skips the setup phase.
//
// Optional feature: define APB_SLV_PSTRB_EN to enable byte strobes on writes.
// Without the macro, pstrb is ignored and every write updates the full word.
//
// Ports:
//   pclk     in   APB clock; all state changes on the rising edge
//   presetn  in   asynchronous active-low reset
//   psel     in   slave select
//   penable  in   access phase
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address [ADDR_WIDTH]
//   pwdata   in   write data [DATA_WIDTH]
//   pstrb    in   byte strobes [DATA_WIDTH/8]
//   prdata   out  registered read data [DATA_WIDTH]
//   pready   out  transfer complete
//   pslverr  out  error response, meaningful only while pready=1
module apb_mem_slave_param #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LG = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]            state;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- decode
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] word;
  logic [IW-1:0]         idx;
  logic                  range_err;
  logic                  align_err;
  logic                  err;

  assign off  = paddr - BASE_ADDR;
  assign word = off >> LG;
  assign idx  = word[IW-1:0];
  // The full-width word index is checked, so addresses far above the window
  // cannot alias back onto a valid word.
  assign range_err = (paddr < BASE_ADDR) || (word >= ADDR_WIDTH'(DEPTH));

  generate
    if (LG > 0) begin : g_align
      assign align_err = |paddr[LG-1:0];
    end else begin : g_no_align
      assign align_err = 1'b0;
    end
  endgenerate

  assign err = range_err | align_err;

  // -------------------------------------------------------- handshake terms
  logic access_done;
  logic proto_err;

  assign access_done = (state == ACCESS) & psel & penable & (cnt == WC);
  // An access phase that arrives while idle has no setup phase. It is answered
  // at once with an error and does not touch memory.
  assign proto_err   = (state == IDLE) & psel & penable;

  assign pready  = presetn & (access_done | proto_err);
  assign pslverr = presetn & ((access_done & err) | proto_err);

  // ------------------------------------------------------------ lane enables
  logic [NB-1:0] lane_we;

`ifdef APB_SLV_PSTRB_EN
  assign lane_we = pstrb;
`else
  logic unused_pstrb;
  assign unused_pstrb = ^pstrb;
  assign lane_we      = '1;
`endif

  logic wr_commit;
  assign wr_commit = access_done & pwrite & ~err;

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state  <= IDLE;
      cnt    <= '0;
      prdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state <= ACCESS;
            cnt   <= '0;
            // Read data is captured at the setup edge. A write completing on
            // the previous edge is therefore already visible here.
            if (!pwrite) begin
              prdata <= err ? '0 : mem[idx];
            end
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;               // master abort: drop the transfer
          end else if (access_done) begin
            state <= IDLE;
          end else if (penable && (cnt != WC)) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- memory
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (wr_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (lane_we[b]) begin
          mem[idx][b*8 +: 8] <= pwdata[b*8 +: 8];
        end
      end
    end
  end

endmodule
